// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative, write-back, write-allocate data cache
// with one LRU bit per set and 4-byte (one memory word) blocks.
// Optional hit/miss/write-back statistics counters are built when the macro
// DCACHE_2WAY_STATS_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no memory traffic; hits complete here, a miss starts refill
// WRITEBACK | dirty victim word being written back to memory
// FETCH     | missed block being read from memory
// UPDATE    | fetched word installed into the victim way (one cycle)
`timescale 1ns/1ps
module dcache_2way #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_busywait
`ifdef DCACHE_2WAY_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [15:0]       wb_count
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
    state_t state, state_next;

    logic [1:0]         valid_q [SETS];
    logic [1:0]         dirty_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][2];
    logic [31:0]        data_q  [SETS][2];
    logic [SETS-1:0]    lru_q;
    logic               victim_q;
    logic               victim_sel;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [1:0]         addr_off;
    logic               req;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic               hit_way;
    logic               do_hit;
    logic               miss_start;
    logic [31:0]        hit_word;

    assign addr_tag   = address[ADDR_W-1:INDEX_W+2];
    assign addr_idx   = address[INDEX_W+1:2];
    assign addr_off   = address[1:0];
    assign req        = read || write;
    assign hit0       = valid_q[addr_idx][0] && (tag_q[addr_idx][0] == addr_tag);
    assign hit1       = valid_q[addr_idx][1] && (tag_q[addr_idx][1] == addr_tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign hit_word   = data_q[addr_idx][hit_way];
    assign do_hit     = (state == IDLE) && req && hit;
    assign miss_start = (state == IDLE) && req && !hit;

    // Empty ways are filled before anything is evicted; otherwise LRU decides.
    assign victim_sel = !valid_q[addr_idx][0] ? 1'b0 :
                        !valid_q[addr_idx][1] ? 1'b1 : lru_q[addr_idx];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: refill sequence, skipping write-back for clean victims.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (miss_start) begin
                    if (valid_q[addr_idx][victim_sel] && dirty_q[addr_idx][victim_sel])
                        state_next = WRITEBACK;
                    else
                        state_next = FETCH;
                end
            end
            WRITEBACK: if (!mem_busywait) state_next = FETCH;
            FETCH:     if (!mem_busywait) state_next = UPDATE;
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs: memory handshake, CPU stall and the load byte of the hit way.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = address[ADDR_W-1:2];
        mem_writedata = data_q[addr_idx][victim_q];
        case (state)
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_q[addr_idx][victim_q], addr_idx};
            end
            FETCH:   mem_read = 1'b1;
            default: ;
        endcase
        busywait = req && ((state != IDLE) || !hit);
        readdata = hit_word[{addr_off, 3'b000} +: 8];
    end

    // Metadata: valid/dirty/lru and the victim latched when a miss is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            if (miss_start) victim_q <= victim_sel;
            if (do_hit) begin
                lru_q[addr_idx] <= ~hit_way;
                if (write) dirty_q[addr_idx][hit_way] <= 1'b1;
            end
            if (state == UPDATE) begin
                valid_q[addr_idx][victim_q] <= 1'b1;
                dirty_q[addr_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Data and tag arrays: not cleared by reset, but a reset edge blocks any update.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (do_hit && write)
                data_q[addr_idx][hit_way][{addr_off, 3'b000} +: 8] <= writedata;
            if (state == UPDATE) begin
                data_q[addr_idx][victim_q] <= mem_readdata;
                tag_q[addr_idx][victim_q]  <= addr_tag;
            end
        end
    end

`ifdef DCACHE_2WAY_STATS_EN
    logic filled_q;

    // Marks the IDLE cycle right after a refill so its completing hit is not counted.
    always_ff @(posedge clock) begin
        if (reset) filled_q <= 1'b0;
        else       filled_q <= (state == UPDATE);
    end

    // Saturating statistics counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (do_hit && !filled_q && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (miss_start && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
            if ((state == WRITEBACK) && (state_next == FETCH) && (wb_count != 16'hFFFF))
                wb_count <= wb_count + 16'd1;
        end
    end
`endif
endmodule

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- Parametrised two-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the 32-bit-word data memory.
- Successor to the current direct-mapped cache:
  - address width and set count are parameters;
  - each set holds two ways with one LRU bit per set;
  - reset and all state updates are synchronous.
- Blocks are 4 bytes, which is one memory word.

Parameters:
- ADDR_W, 8, CPU byte-address width. Must be at least INDEX_W+3.
- INDEX_W, 2, set index width. The cache has 2^INDEX_W sets.
- Derived, not overridable: TAG_W = ADDR_W-INDEX_W-2. Address fields are tag = address[ADDR_W-1:INDEX_W+2], index = address[INDEX_W+1:2], offset = address[1:0].

Ports:
- clock, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- read, input, 1: CPU load request.
- write, input, 1: CPU store request.
- address, input, ADDR_W: CPU byte address.
- writedata, input, 8: store byte.
- readdata, output, 8: load byte.
- busywait, output, 1: CPU stall.
- mem_read, output, 1: memory read request.
- mem_write, output, 1: memory write request.
- mem_address, output, ADDR_W-2: memory block address.
- mem_writedata, output, 32: write-back word.
- mem_readdata, input, 32: fetched word.
- mem_busywait, input, 1: memory busy.

Behaviour:
- Per-set state: valid[2], dirty[2], tag[2], data[2] (32 bits each), and lru (1 bit; it names the way to evict next).
- Reset (synchronous, on a clock edge with reset=1):
  - all valid, dirty and lru bits cleared; state set to IDLE;
  - data and tag arrays not cleared.
- Outputs:
  - mem_read and mem_write are 0 from the edge after reset is sampled;
  - busywait follows its combinational equation;
  - reset asserted mid-miss abandons the transfer with no array update.
- Hit, combinational: hit_w = valid[w] && tag[w]==addr_tag. Both ways hitting cannot occur.
- busywait = (read||write) && (state!=IDLE || !hit).
- Read hit:
  - readdata = byte <offset> of the hit way's word, valid in the same cycle;
  - zero stall cycles;
  - at the edge, lru is set to the other way.
- Write hit:
  - zero stall cycles;
  - at the edge, byte <offset> of the hit way is written, dirty set, lru set to the other way.
- read and write both high: treated as a write.
- When no request is active or on a miss, readdata is don't-care.
- Victim selection on a miss:
  - invalid way0 first, then invalid way1, otherwise the way named by lru;
  - the victim is latched at miss detection and held until the update completes.
- FSM states:
  - IDLE: no memory request. On (read||write) && !hit, go to WRITEBACK if the victim is valid and dirty, else go to FETCH.
  - WRITEBACK:
    - mem_write=1, mem_address={victim_tag, index}, mem_writedata = victim word;
    - stay while mem_busywait=1, then go to FETCH.
  - FETCH:
    - mem_read=1, mem_address=address[ADDR_W-1:2];
    - stay while mem_busywait=1, then go to UPDATE.
  - UPDATE:
    - one cycle; mem_read and mem_write are 0;
    - at the edge, the victim way gets data=mem_readdata, tag=addr_tag, valid=1, dirty=0;
    - go to IDLE, where the request now hits and completes as a hit.
- Miss cost:
  - clean miss = fetch cycles + 1 (UPDATE) + 1 (hit cycle);
  - dirty miss adds the write-back cycles.
- The CPU holds read, write, address and writedata stable while busywait=1.
- mem_readdata is sampled at the UPDATE edge, so memory holds it one cycle after dropping mem_busywait.
- Requests arriving in a non-IDLE state are ignored until the FSM returns to IDLE.

Optional Feature:
- Macro: DCACHE_2WAY_STATS_EN.
- When defined, three extra outputs are added: hit_count, miss_count and wb_count, each 16 bits.
  - All three are cleared by reset and saturate at 0xFFFF.
  - hit_count increments on each completed hit edge; a miss's final hit cycle does not count as a hit.
  - miss_count increments once per IDLE->WRITEBACK or IDLE->FETCH transition.
  - wb_count increments once per WRITEBACK->FETCH transition.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan (defaults ADDR_W=8, INDEX_W=2; memory model with 5-cycle busywait):
- Reset, then read 0x04 → clean miss: FETCH with mem_address=0x01, UPDATE, then readdata = byte0 of the memory word; no mem_write; busywait drops one cycle after UPDATE.
- Write 0x04 ← 0xAA, then read 0x04 → both complete with zero stall cycles; readdata=0xAA; dirty set in way0, set 1.
- Read 0x14 (same set 1) → fills way1 with no write-back. Read 0x04 → hit, lru=1. Read 0x24 → evicts way1 (clean): no mem_write, FETCH mem_address=0x09.
- Write 0x34 ← 0x55 (lru=0, way0 dirty) → WRITEBACK: mem_address=0x01, mem_writedata[7:0]=0xAA; then FETCH mem_address=0x0D; then a read of 0x34 returns 0x55.
- Assert reset during FETCH → next cycle mem_read=0 and state IDLE. A following read of 0x04 misses (valid cleared).
- With DCACHE_2WAY_STATS_EN defined, run the four scenarios above → hit_count, miss_count and wb_count match the bench's count of hit edges, IDLE miss transitions and WRITEBACK->FETCH transitions (expected wb_count=1). Forcing 0xFFFF more hits leaves hit_count at 0xFFFF.
